// File: rtl/odu_test_pkg.sv
// ODU test data generator: shared constants, per-channel state and lane pattern.
package odu_test_pkg;

  localparam int NUM_CH    = 80;
  localparam int DATA_W    = 384;
  localparam int ROW_WORDS = 80;
  localparam int ROWS      = 4;
  localparam int LANE_W    = 32;
  localparam int LANES     = DATA_W / LANE_W;
  localparam int CH_W      = 7;

  typedef struct packed {
    logic [7:0] mfas;
    logic [1:0] row;
    logic [6:0] word;
  } ch_state_t;

  function automatic logic [DATA_W-1:0] lane_pattern(
    input logic [CH_W-1:0] chid,
    input ch_state_t       st
  );
    logic [DATA_W-1:0] d;
    logic [3:0]        k4;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      k4 = 4'(k);
      d[LANE_W*k +: LANE_W] = {4'b0, chid, st.mfas, st.row, st.word, k4};
    end
    return d;
  endfunction

endpackage

// File: rtl/odu_test_data_gen_rr_sel.sv
// Round-robin pick: first set mask bit at or after the pointer, wrapping.
module odu_rr_sel
  import odu_test_pkg::*;
#(
  parameter int N = odu_test_pkg::NUM_CH
) (
  input  logic [N-1:0]    mask_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [CH_W-1:0] grant_o,
  output logic            found_o
);

  logic [CH_W:0]   sum;
  logic [CH_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(N)) begin
        sum = sum - (CH_W+1)'(N);
      end
      idx = sum[CH_W-1:0];
      if (!found_o && mask_i[idx]) begin
        found_o = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/odu_test_data_gen.sv
// ODU test payload generator, round-robin over enabled channels.
// Define ODU_TEST_ERR_INJECT_EN to build the single-word bit-0 error injector.
module odu_test_data_gen #(
  parameter int NUM_CH    = odu_test_pkg::NUM_CH,
  parameter int DATA_W    = odu_test_pkg::DATA_W,
  parameter int ROW_WORDS = odu_test_pkg::ROW_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_enable_chid,
  input  logic              i_ready,
  input  logic              i_err_inject,
  input  logic [6:0]        i_err_chid,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_fs,
  output logic              o_rs,
  output logic [7:0]        o_mfas,
  output logic [6:0]        o_chid
);
  import odu_test_pkg::*;

  ch_state_t st_q [NUM_CH];

  logic [6:0]        ptr_q;
  logic [6:0]        ptr_d;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              fs_q;
  logic              rs_q;
  logic [7:0]        mfas_q;
  logic [6:0]        chid_q;

  logic [6:0] grant;
  logic       found;
  logic       load;
  logic       take;
  logic       flip;
  ch_state_t  gst;
  ch_state_t  st_adv;

  odu_rr_sel #(
    .N(NUM_CH)
  ) u_rr_sel (
    .mask_i  (i_enable_chid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .found_o (found)
  );

  assign load = !valid_q || i_ready;
  assign take = load && found;
  assign gst  = st_q[grant];

`ifdef ODU_TEST_ERR_INJECT_EN
  logic       err_arm_q;
  logic [6:0] err_ch_q;

  assign flip = err_arm_q && (err_ch_q == grant);

  // A new pulse re-arms and retargets even while a flip is pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_arm_q <= 1'b0;
      err_ch_q  <= '0;
    end else if (i_err_inject) begin
      err_arm_q <= 1'b1;
      err_ch_q  <= i_err_chid;
    end else if (take && flip) begin
      err_arm_q <= 1'b0;
    end
  end
`else
  logic unused_err;

  assign flip       = 1'b0;
  assign unused_err = ^{i_err_inject, i_err_chid};
`endif

  always_comb begin
    st_adv = gst;
    if (gst.word == 7'(ROW_WORDS-1)) begin
      st_adv.word = '0;
      st_adv.row  = gst.row + 2'd1;
      if (gst.row == 2'(ROWS-1)) begin
        st_adv.mfas = gst.mfas + 8'd1;
      end
    end else begin
      st_adv.word = gst.word + 7'd1;
    end
  end

  always_comb begin
    data_d    = lane_pattern(grant, gst);
    data_d[0] = data_d[0] ^ flip;
  end

  assign ptr_d = (grant == 7'(NUM_CH-1)) ? '0 : grant + 7'd1;

  // Disabled channels restart from frame start when re-enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!i_enable_chid[c]) begin
          st_q[c] <= '0;
        end else if (take && grant == 7'(c)) begin
          st_q[c] <= st_adv;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      fs_q    <= 1'b0;
      rs_q    <= 1'b0;
      mfas_q  <= '0;
      chid_q  <= '0;
    end else if (load) begin
      valid_q <= found;
      if (found) begin
        ptr_q  <= ptr_d;
        data_q <= data_d;
        chid_q <= grant;
        fs_q   <= (gst.word == '0) && (gst.row == '0);
        rs_q   <= (gst.word == '0);
        mfas_q <= gst.mfas;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_fs    = fs_q;
  assign o_rs    = rs_q;
  assign o_mfas  = mfas_q;
  assign o_chid  = chid_q;

endmodule
